// File: rtl/mine_count_if.sv
// Handshake and read-port bundle between the placement/reveal logic and mine_count.
// Optional zero_map signal exists only when MINE_COUNT_ZERO_MAP_EN is defined.
`timescale 1ns/1ps
interface mine_count_if #(
   parameter int N_ROWS = 5,
   parameter int N_COLS = 5
);
   localparam int CELLS = N_ROWS * N_COLS;
   localparam int IW    = $clog2(CELLS);

   logic             start;
   logic             place_done;
   logic [CELLS-1:0] mines;
   logic [IW-1:0]    rd_index;
   logic [3:0]       rd_count;
   logic             rd_mine;
   logic             count_busy;
   logic             wr_valid;
   logic [IW-1:0]    wr_index;
   logic [3:0]       wr_count;
   logic             count_done;
`ifdef MINE_COUNT_ZERO_MAP_EN
   logic [CELLS-1:0] zero_map;
`endif

   modport master (
      output start, place_done, mines, rd_index,
      input  rd_count, rd_mine, count_busy, wr_valid, wr_index, wr_count, count_done
`ifdef MINE_COUNT_ZERO_MAP_EN
      , input zero_map
`endif
   );

   modport slave (
      input  start, place_done, mines, rd_index,
      output rd_count, rd_mine, count_busy, wr_valid, wr_index, wr_count, count_done
`ifdef MINE_COUNT_ZERO_MAP_EN
      , output zero_map
`endif
   );
endinterface

// File: rtl/mine_count.sv
// Scans the latched mine map one cell per clock, streaming and tabulating adjacent-mine counts.
// Optional MINE_COUNT_ZERO_MAP_EN adds a per-cell "empty and zero" map for flood-fill reveal.
`timescale 1ns/1ps
module mine_count #(
   parameter int N_ROWS = 5,
   parameter int N_COLS = 5
) (
   input logic         clka,
   input logic         restart_n,
   mine_count_if.slave bus
);
   localparam int CELLS = N_ROWS * N_COLS;
   localparam int IW    = $clog2(CELLS);
   localparam int RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [RW-1:0]          row_q, row_d;
   logic [CW-1:0]          col_q, col_d;
   logic [CELLS-1:0]       mine_q, mine_d;
   logic [CELLS-1:0][3:0]  tbl_q, tbl_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [IW-1:0]          wr_index_q, wr_index_d;
   logic [3:0]             wr_count_q, wr_count_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
`ifdef MINE_COUNT_ZERO_MAP_EN
   logic [CELLS-1:0]       zmap_q, zmap_d;
`endif

   logic [3:0] cnt;
   int         nr, nc;

   // Row/col are tracked alongside idx so neighbour bounds need no divider.
   always_comb begin
      cnt = '0;
      nr  = 0;
      nc  = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            nr = int'(row_q) + dr;
            nc = int'(col_q) + dc;
            if ((dr != 0 || dc != 0) && nr >= 0 && nr < N_ROWS && nc >= 0 && nc < N_COLS)
               cnt = cnt + {3'b000, mine_q[IW'(nr * N_COLS + nc)]};
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      row_d      = row_q;
      col_d      = col_q;
      mine_d     = mine_q;
      tbl_d      = tbl_q;
      wr_valid_d = 1'b0;
      wr_index_d = '0;
      wr_count_d = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
`ifdef MINE_COUNT_ZERO_MAP_EN
      zmap_d     = zmap_q;
`endif
      if (bus.start) begin
         state_d = IDLE;
         idx_d   = '0;
         row_d   = '0;
         col_d   = '0;
         mine_d  = '0;
         tbl_d   = '0;
`ifdef MINE_COUNT_ZERO_MAP_EN
         zmap_d  = '0;
`endif
      end else begin
         case (state_q)
            IDLE: if (bus.place_done) begin
               mine_d  = bus.mines;
               idx_d   = '0;
               row_d   = '0;
               col_d   = '0;
               busy_d  = 1'b1;
               state_d = SCAN;
            end
            SCAN: begin
               tbl_d[idx_q] = cnt;
               wr_valid_d   = 1'b1;
               wr_index_d   = idx_q;
               wr_count_d   = cnt;
`ifdef MINE_COUNT_ZERO_MAP_EN
               zmap_d[idx_q] = (cnt == 4'd0) && !mine_q[idx_q];
`endif
               if (idx_q == IW'(CELLS - 1)) begin
                  idx_d   = '0;
                  row_d   = '0;
                  col_d   = '0;
                  state_d = DONE;
               end else begin
                  busy_d = 1'b1;
                  idx_d  = idx_q + 1'b1;
                  if (col_q == CW'(N_COLS - 1)) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
            DONE: begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         mine_q     <= '0;
         tbl_q      <= '0;
         wr_valid_q <= 1'b0;
         wr_index_q <= '0;
         wr_count_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MINE_COUNT_ZERO_MAP_EN
         zmap_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         row_q      <= row_d;
         col_q      <= col_d;
         mine_q     <= mine_d;
         tbl_q      <= tbl_d;
         wr_valid_q <= wr_valid_d;
         wr_index_q <= wr_index_d;
         wr_count_q <= wr_count_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef MINE_COUNT_ZERO_MAP_EN
         zmap_q     <= zmap_d;
`endif
      end
   end

   logic [3:0] rd_count_w;
   logic       rd_mine_w;

   // Compare in 32 bits so a power-of-two CELLS does not truncate the bound.
   always_comb begin
      rd_count_w = '0;
      rd_mine_w  = 1'b0;
      if (32'(bus.rd_index) < CELLS) begin
         rd_count_w = tbl_q[bus.rd_index];
         rd_mine_w  = mine_q[bus.rd_index];
      end
   end

   assign bus.rd_count   = rd_count_w;
   assign bus.rd_mine    = rd_mine_w;
   assign bus.count_busy = busy_q;
   assign bus.wr_valid   = wr_valid_q;
   assign bus.wr_index   = wr_index_q;
   assign bus.wr_count   = wr_count_q;
   assign bus.count_done = done_q;
`ifdef MINE_COUNT_ZERO_MAP_EN
   assign bus.zero_map   = zmap_q;
`endif
endmodule

// File: tb/tb_mine_count.sv
// Directed bench for mine_count on the default 5x5 board.
`timescale 1ns/1ps
module tb_mine_count;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mine_count_if #(.N_ROWS(5), .N_COLS(5)) bus ();
   mine_count #(.N_ROWS(5), .N_COLS(5)) dut (.clka(clk), .restart_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int exp_cnt [25];
   int done_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_mask(input logic [24:0] m);
      for (int i = 0; i < 25; i++) exp_cnt[i] = m[i] ? 1 : 0;
   endtask

   // Pulse place_done, then check each streamed result and the done pulse timing.
   task automatic scan(input logic [24:0] m, input string tag, input bit inject);
      @(negedge clk);
      bus.mines = m;
      bus.place_done = 1'b1;
      @(negedge clk);
      bus.place_done = 1'b0;
      chk($sformatf("%s busy_rise", tag), 32'(bus.count_busy), 1);
      chk($sformatf("%s no_wr_yet", tag), 32'(bus.wr_valid), 0);
      for (int k = 0; k < 25; k++) begin
         if (inject && k == 10) begin
            bus.place_done = 1'b1;
            bus.mines = '0;
         end
         @(negedge clk);
         bus.place_done = 1'b0;
         chk($sformatf("%s wr_valid[%0d]", tag, k), 32'(bus.wr_valid), 1);
         chk($sformatf("%s wr_index[%0d]", tag, k), 32'(bus.wr_index), k);
         chk($sformatf("%s wr_count[%0d]", tag, k), 32'(bus.wr_count), exp_cnt[k]);
         chk($sformatf("%s early_done[%0d]", tag, k), 32'(bus.count_done), 0);
      end
      @(negedge clk);
      chk($sformatf("%s count_done", tag), 32'(bus.count_done), 1);
      chk($sformatf("%s busy_fall", tag), 32'(bus.count_busy), 0);
      chk($sformatf("%s wr_off", tag), 32'(bus.wr_valid), 0);
      done_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.count_done) done_seen++;
      end
      chk($sformatf("%s single_done", tag), done_seen, 0);
   endtask

   task automatic check_table(input logic [24:0] m, input string tag);
      for (int i = 0; i < 25; i++) begin
         bus.rd_index = 5'(i);
         #1;
         chk($sformatf("%s rd_count[%0d]", tag, i), 32'(bus.rd_count), exp_cnt[i]);
         chk($sformatf("%s rd_mine[%0d]", tag, i), 32'(bus.rd_mine), 32'(m[i]));
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.place_done = 1'b0;
      bus.mines = '0;
      bus.rd_index = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(bus.count_busy), 0);
      chk("reset wr_valid", 32'(bus.wr_valid), 0);
      chk("reset wr_index", 32'(bus.wr_index), 0);
      chk("reset wr_count", 32'(bus.wr_count), 0);
      chk("reset done", 32'(bus.count_done), 0);
      chk("reset rd_count", 32'(bus.rd_count), 0);
      chk("reset rd_mine", 32'(bus.rd_mine), 0);
      rst_n = 1'b1;

      // Centre mine
      set_mask(25'h00729C0);
      scan(25'h1 << 12, "centre", 1'b0);
      check_table(25'h1 << 12, "centre");
`ifdef MINE_COUNT_ZERO_MAP_EN
      chk("centre zero_map", 32'(bus.zero_map), 32'h1F8C63F);
`endif

      // Right edge of row 0: cell 5 must stay 0 (no wrap)
      set_mask(25'h0000308);
      scan(25'h1 << 4, "edge4", 1'b0);
      check_table(25'h1 << 4, "edge4");

      set_mask(25'h0000062);
      scan(25'h1, "corner0", 1'b0);
      check_table(25'h1, "corner0");

      exp_cnt = '{3,5,5,5,3, 5,8,8,8,5, 5,8,8,8,5, 5,8,8,8,5, 3,5,5,5,3};
      scan(25'h1FFFFFF, "full", 1'b0);
      check_table(25'h1FFFFFF, "full");
`ifdef MINE_COUNT_ZERO_MAP_EN
      chk("full zero_map", 32'(bus.zero_map), 0);
`endif
      bus.rd_index = 5'd25;
      #1;
      chk("oob25 rd_count", 32'(bus.rd_count), 0);
      chk("oob25 rd_mine", 32'(bus.rd_mine), 0);
      bus.rd_index = 5'd31;
      #1;
      chk("oob31 rd_count", 32'(bus.rd_count), 0);
      chk("oob31 rd_mine", 32'(bus.rd_mine), 0);

      // Second place_done mid-scan is ignored
      set_mask(25'h00729C0);
      scan(25'h1 << 12, "ignore", 1'b1);
      check_table(25'h1 << 12, "ignore");

      // Async reset mid-scan
      @(negedge clk);
      bus.mines = 25'h1 << 12;
      bus.place_done = 1'b1;
      @(negedge clk);
      bus.place_done = 1'b0;
      repeat (7) @(negedge clk);
      bus.rd_index = 5'd6;
      #1;
      chk("pre_rst cell6", 32'(bus.rd_count), 1);
      rst_n = 1'b0;
      #1;
      chk("rst wr_valid", 32'(bus.wr_valid), 0);
      chk("rst busy", 32'(bus.count_busy), 0);
      chk("rst wr_index", 32'(bus.wr_index), 0);
      chk("rst wr_count", 32'(bus.wr_count), 0);
      chk("rst cell6", 32'(bus.rd_count), 0);
      bus.rd_index = 5'd12;
      #1;
      chk("rst mine12", 32'(bus.rd_mine), 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.count_done || bus.wr_valid) done_seen++;
      end
      chk("rst no_done", done_seen, 0);

      // Synchronous start mid-scan
      @(negedge clk);
      bus.mines = 25'h1 << 12;
      bus.place_done = 1'b1;
      @(negedge clk);
      bus.place_done = 1'b0;
      repeat (7) @(negedge clk);
      bus.rd_index = 5'd6;
      #1;
      chk("pre_start cell6", 32'(bus.rd_count), 1);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start wr_valid", 32'(bus.wr_valid), 0);
      chk("start busy", 32'(bus.count_busy), 0);
      chk("start done", 32'(bus.count_done), 0);
      chk("start cell6", 32'(bus.rd_count), 0);
      bus.rd_index = 5'd12;
      #1;
      chk("start mine12", 32'(bus.rd_mine), 0);
      done_seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.count_done || bus.wr_valid) done_seen++;
      end
      chk("start no_done", done_seen, 0);

      // start wins over a simultaneous place_done
      @(negedge clk);
      bus.start = 1'b1;
      bus.place_done = 1'b1;
      bus.mines = 25'h1FFFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      bus.place_done = 1'b0;
      bus.rd_index = 5'd0;
      #1;
      chk("prio busy", 32'(bus.count_busy), 0);
      chk("prio mine0", 32'(bus.rd_mine), 0);
      @(negedge clk);
      chk("prio wr_valid", 32'(bus.wr_valid), 0);

      // Fresh full scan after the abort
      set_mask(25'h0000062);
      scan(25'h1, "rescan", 1'b0);
      check_table(25'h1, "rescan");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
